// File: rtl/press_emu_pkg.sv
// Shared types and sizing helpers for the press emulator.
// Optional build macro: PRESS_EMU_RETRIGGER_EN (see press_emulator.sv).
package press_emu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_MAX_PEND    = 15;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/press_emu_timer.sv
// Loadable down-counter shared by the hold and gap phases; stops at zero.
module press_emu_timer #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] value;

    // Load wins over decrement so a phase change always starts from a full count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/press_emulator.sv
// Turns single-cycle request strobes into timed button presses (hold, then gap).
// Build macro PRESS_EMU_RETRIGGER_EN: a strobe during a press extends it instead of queueing.
module press_emulator
    import press_emu_pkg::*;
#(
    parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter  int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter  int MAX_PEND    = DEF_MAX_PEND,
    localparam int PW          = bits_for(MAX_PEND + 1),
    localparam int TW          = bits_for(max2(HOLD_CYCLES, GAP_CYCLES))
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          pi,
    output logic          bo,
    output logic          busy,
    output logic [PW-1:0] pend_cnt,
    output logic          ovf
);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

    state_t        state, next_state;
    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic          consume, retrig, queue_req;

`ifdef PRESS_EMU_RETRIGGER_EN
    assign retrig = pi && (state == S_HOLD);
`else
    assign retrig = 1'b0;
`endif

    assign queue_req = pi && !retrig;

    press_emu_timer #(.W(TW)) u_timer (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            bo    <= 1'b0;
        end else begin
            state <= next_state;
            bo    <= (next_state == S_HOLD);
        end
    end

    // A press starts (consume) from idle, or straight out of a finished gap.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        consume    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_cnt != '0) begin
                    next_state = S_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = HOLD_LOAD;
                    consume    = 1'b1;
                end
            end
            S_HOLD: begin
                if (retrig) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    next_state = S_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (pend_cnt != '0) begin
                    next_state = S_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = HOLD_LOAD;
                    consume    = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // A strobe and a consume in the same cycle cancel, so saturation only drops when nothing leaves.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (queue_req && !consume) begin
                if (pend_cnt == PEND_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + PW'(1);
                end
            end else if (consume && !queue_req) begin
                pend_cnt <= pend_cnt - PW'(1);
            end
        end
    end

    assign busy = (state != S_IDLE) || (pend_cnt != '0);

endmodule

// File: tb/tb_press_emulator.sv
// Directed self-checking bench for press_emulator (HOLD=4, GAP=2, MAX_PEND=15).
// Edge numbers count rising edges after reset release; outputs are sampled 1ns after each edge.
module tb_press_emulator;

    logic       Clk;
    logic       Rst_n;
    logic       pi;
    logic       bo;
    logic       busy;
    logic [3:0] pend_cnt;
    logic       ovf;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    press_emulator #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .MAX_PEND    (15)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .pi       (pi),
        .bo       (bo),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .ovf      (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Drive pi for the next edge, then advance past it.
    task automatic applyStimulus(input logic v);
        pi = v;
        tick();
    endtask

    task automatic go_to(input int n);
        while (cyc < n) applyStimulus(1'b0);
    endtask

    task automatic doReset();
        pi    = 1'b0;
        Rst_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        pi    = 1'b0;
        Rst_n = 1'b0;
        #3;
        nChecks++;
        if ({bo, busy, pend_cnt, ovf} !== 7'b0) begin
            nFails++;
            $display("[TB] FAIL reset_state: got bo=%b busy=%b pend=%0d ovf=%b, want all 0",
                     bo, busy, pend_cnt, ovf);
        end
        doReset();
        tick();
        nChecks++;
        if ({bo, busy, pend_cnt, ovf} !== 7'b0) begin
            nFails++;
            $display("[TB] FAIL idle_after_reset: got bo=%b busy=%b pend=%0d ovf=%b, want all 0",
                     bo, busy, pend_cnt, ovf);
        end
    endtask

    task automatic test_single();
        logic expBo, expBusy;
        doReset();
        go_to(9);
        for (int e = 10; e <= 19; e++) begin
            applyStimulus(e == 10);
            expBo   = (e >= 11 && e <= 14);
            expBusy = (e <= 16);
            nChecks++;
            if (bo !== expBo || busy !== expBusy) begin
                nFails++;
                $display("[TB] FAIL single edge %0d: got bo=%b busy=%b, want bo=%b busy=%b",
                         e, bo, busy, expBo, expBusy);
            end
            if (e == 10) begin
                nChecks++;
                if (pend_cnt !== 4'd1) begin
                    nFails++;
                    $display("[TB] FAIL single_latency: got pend=%0d, want 1", pend_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        doReset();
        go_to(9);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        #2;
        nChecks++;
        if (bo !== 1'b1 || pend_cnt !== 4'd1) begin
            nFails++;
            $display("[TB] FAIL pre_reset: got bo=%b pend=%0d, want bo=1 pend=1", bo, pend_cnt);
        end
        Rst_n = 1'b0;
        #1;
        nChecks++;
        if (bo !== 1'b0 || busy !== 1'b0 || pend_cnt !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL async_reset: got bo=%b busy=%b pend=%0d, want 0 0 0",
                     bo, busy, pend_cnt);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            nChecks++;
            if (bo !== 1'b0 || busy !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL no_replay edge %0d: got bo=%b busy=%b, want 0 0", cyc, bo, busy);
            end
        end
    endtask

    task automatic test_retrigger();
        logic       expBo;
        logic [3:0] expPend;
        doReset();
        go_to(9);
        for (int e = 10; e <= 22; e++) begin
            applyStimulus(e == 10 || e == 13);
`ifdef PRESS_EMU_RETRIGGER_EN
            expBo   = (e >= 11 && e <= 16);
            expPend = (e == 10) ? 4'd1 : 4'd0;
`else
            expBo   = (e >= 11 && e <= 14) || (e >= 17 && e <= 20);
            expPend = (e == 10 || (e >= 13 && e <= 16)) ? 4'd1 : 4'd0;
`endif
            nChecks++;
            if (bo !== expBo || pend_cnt !== expPend) begin
                nFails++;
                $display("[TB] FAIL retrigger edge %0d: got bo=%b pend=%0d, want bo=%b pend=%0d",
                         e, bo, pend_cnt, expBo, expPend);
            end
`ifdef PRESS_EMU_RETRIGGER_EN
            if (e == 17) begin
                nChecks++;
                if (busy !== 1'b1) begin
                    nFails++;
                    $display("[TB] FAIL retrigger_gap: got busy=%b, want 1", busy);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic       expBo, expBusy;
        logic [3:0] expPend;
        int         peak = 0;
        doReset();
        go_to(9);
        for (int e = 10; e <= 31; e++) begin
            applyStimulus(e >= 10 && e <= 12);
            expBo   = (e >= 11 && e <= 14) || (e >= 17 && e <= 20) || (e >= 23 && e <= 26);
            expBusy = (e <= 28);
            expPend = (e >= 12 && e <= 16) ? 4'd2 :
                      ((e <= 11) || (e >= 17 && e <= 22)) ? 4'd1 : 4'd0;
            if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
            nChecks++;
            if (bo !== expBo || busy !== expBusy || pend_cnt !== expPend) begin
                nFails++;
                $display("[TB] FAIL back_to_back edge %0d: got bo=%b busy=%b pend=%0d, want %b %b %0d",
                         e, bo, busy, pend_cnt, expBo, expBusy, expPend);
            end
        end
        nChecks++;
        if (peak != 2) begin
            nFails++;
            $display("[TB] FAIL pend_peak: got %0d, want 2", peak);
        end
    endtask

    task automatic test_consume_coincident();
        logic       expBo;
        logic [3:0] expPend;
        doReset();
        go_to(9);
        for (int e = 10; e <= 28; e++) begin
            applyStimulus(e == 10 || e == 12 || e == 17);
            expBo   = (e >= 11 && e <= 14) || (e >= 17 && e <= 20) || (e >= 23 && e <= 26);
            expPend = (e == 10 || (e >= 12 && e <= 22)) ? 4'd1 : 4'd0;
            nChecks++;
            if (bo !== expBo || pend_cnt !== expPend || ovf !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL coincident edge %0d: got bo=%b pend=%0d ovf=%b, want %b %0d 0",
                         e, bo, pend_cnt, ovf, expBo, expPend);
            end
        end
    endtask

    task automatic test_saturation();
        int   presses  = 0;
        int   ovfCount = 0;
        int   hiRun    = 0;
        int   loRun    = 0;
        logic prevBo   = 1'b0;
        doReset();
        go_to(9);
        for (int e = 10; e <= 200; e++) begin
            applyStimulus(e <= 40);
            if (ovf === 1'b1) ovfCount++;
            if (bo === 1'b1) begin
                if (!prevBo) begin
                    presses++;
                    if (presses > 1) begin
                        nChecks++;
                        if (loRun < 2) begin
                            nFails++;
                            $display("[TB] FAIL gap_len edge %0d: got %0d, want >=2", e, loRun);
                        end
                    end
                end
                hiRun++;
                loRun = 0;
            end else begin
                if (prevBo) begin
                    nChecks++;
                    if (hiRun != 4) begin
                        nFails++;
                        $display("[TB] FAIL hold_len edge %0d: got %0d, want 4", e, hiRun);
                    end
                end
                hiRun = 0;
                loRun++;
            end
            prevBo = bo;
            if (e == 27 || e == 29) begin
                nChecks++;
                if (pend_cnt !== 4'd15) begin
                    nFails++;
                    $display("[TB] FAIL sat_level edge %0d: got %0d, want 15", e, pend_cnt);
                end
            end
            if (e == 28 || e == 29 || e == 35) begin
                nChecks++;
                if (ovf !== (e == 28)) begin
                    nFails++;
                    $display("[TB] FAIL ovf_pulse edge %0d: got %b, want %b", e, ovf, (e == 28));
                end
            end
        end
        nChecks++;
        if (ovfCount != 11) begin
            nFails++;
            $display("[TB] FAIL ovf_count: got %0d, want 11", ovfCount);
        end
        nChecks++;
        if (presses != 20) begin
            nFails++;
            $display("[TB] FAIL press_count: got %0d, want 20", presses);
        end
        nChecks++;
        if (busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL sat_drain: got busy=%b, want 0", busy);
        end
    endtask

    initial begin
        pi    = 1'b0;
        Rst_n = 1'b0;
        test_reset();
        test_single();
        test_reset_mid_press();
        test_retrigger();
`ifndef PRESS_EMU_RETRIGGER_EN
        test_back_to_back();
        test_consume_coincident();
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
